// File: rtl/nmk_latch_bank.sv
// ============================================================================
// Module   : nmk_latch_bank
// Purpose  : A/B bus transceiver feeding CH double-buffered channel registers
//            with a sequential commit engine (shadow -> active transfer).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nmk_latch_bank #(
    parameter int WIDTH = 16,
    parameter int CH    = 4,
    parameter int SPLIT = 12,
    parameter int AW    = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  nCS,
    input  logic                  DIR,
    input  logic                  WR,
    input  logic [AW-1:0]         ADDR,
    inout  wire  [WIDTH-1:0]      ABUS,
    inout  wire  [WIDTH-1:0]      BBUS,
    input  logic                  COMMIT,
    input  logic [CH-1:0]         MODE,
    output logic [CH*WIDTH-1:0]   OBUS,
    output logic [CH-1:0]         PEND,
    output logic                  BUSY,
    output logic                  ACK
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(CH - 1);

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic              wr_q;
    logic              wr_ev;
    logic [WIDTH-1:0]  shadow_q [CH];
    logic [WIDTH-1:0]  shadow_d [CH];
    logic [SPLIT-1:0]  active_q [CH];
    logic [SPLIT-1:0]  active_d [CH];
    logic [CH-1:0]     pend_q, pend_d;

    // Enables are mutually exclusive, so the two buses are never both driven.
    assign ABUS = (!nCS &&  DIR) ? BBUS : 'z;
    assign BBUS = (!nCS && !DIR) ? ABUS : 'z;

    assign wr_ev = WR && !wr_q && !nCS && !DIR;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        active_d = active_q;
        pend_d   = pend_q;

        case (state_q)
            S_IDLE: begin
                if (COMMIT) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end
            end
            S_SCAN: begin
                for (int c = 0; c < CH; c++) begin
                    if (idx_q == AW'(c) && pend_q[c]) begin
                        active_d[c] = shadow_q[c][SPLIT-1:0];
                        pend_d[c]   = 1'b0;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Applied after the transfer so a same-edge write keeps PEND set;
        // addresses at or beyond CH match no channel and are dropped.
        for (int c = 0; c < CH; c++) begin
            if (wr_ev && ADDR == AW'(c)) begin
                shadow_d[c] = ABUS;
                pend_d[c]   = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            pend_q  <= '0;
            for (int c = 0; c < CH; c++) begin
                shadow_q[c] <= '0;
                active_q[c] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wr_q     <= WR;
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        if (SPLIT < WIDTH) begin : g_split
            assign OBUS[c*WIDTH +: WIDTH] = MODE[c] ? shadow_q[c]
                                          : {shadow_q[c][WIDTH-1:SPLIT], active_q[c]};
        end else begin : g_full
            assign OBUS[c*WIDTH +: WIDTH] = MODE[c] ? shadow_q[c] : active_q[c];
        end
    end

    assign PEND = pend_q;
    assign BUSY = (state_q != S_IDLE);
    assign ACK  = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_nmk_latch_bank.sv
// ============================================================================
// Module   : tb_nmk_latch_bank
// Purpose  : Directed and random stimulus against a cycle-level channel model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nmk_latch_bank;

    localparam int WIDTH = 16;
    localparam int CH    = 4;
    localparam int SPLIT = 12;
    localparam int AW    = 3;
    localparam logic [WIDTH-1:0] TMASK = ~((16'h1 << SPLIT) - 16'h1);

    logic                clk = 1'b0;
    logic                rst, ncs, dir, wr, commit;
    logic [AW-1:0]       addr;
    logic [CH-1:0]       mode;
    logic [WIDTH-1:0]    a_drv, b_drv;
    logic                a_oe, b_oe;
    wire  [WIDTH-1:0]    abus, bbus;
    logic [CH*WIDTH-1:0] obus;
    logic [CH-1:0]       pend;
    logic                busy, ack;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: channel contents plus a scan-progress counter
    // (0 = idle, 1..CH = visiting channel ph-1, CH+1 = finished).
    logic [WIDTH-1:0] m_sh [CH];
    logic [SPLIT-1:0] m_ac [CH];
    logic [CH-1:0]    m_pend;
    int               m_ph;
    logic             m_wr_prev;

    assign abus = a_oe ? a_drv : 'z;
    assign bbus = b_oe ? b_drv : 'z;

    always #5 clk = ~clk;

    nmk_latch_bank #(.WIDTH(WIDTH), .CH(CH), .SPLIT(SPLIT), .AW(AW)) dut (
        .CLK(clk), .RST(rst), .nCS(ncs), .DIR(dir), .WR(wr), .ADDR(addr),
        .ABUS(abus), .BBUS(bbus), .COMMIT(commit), .MODE(mode),
        .OBUS(obus), .PEND(pend), .BUSY(busy), .ACK(ack)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic apply_bus();
        if (ncs) begin
            a_oe = 1'b1; b_oe = 1'b1;
        end else if (dir) begin
            a_oe = 1'b0; b_oe = 1'b1;
        end else begin
            a_oe = 1'b1; b_oe = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_sh[c] = '0;
            m_ac[c] = '0;
        end
        m_pend    = '0;
        m_ph      = 0;
        m_wr_prev = 1'b0;
    endtask

    task automatic model_edge();
        bit ev;
        int nph;
        ev = wr && !m_wr_prev && !ncs && !dir && (int'(addr) < CH);
        m_wr_prev = wr;
        if (m_ph == 0)       nph = commit ? 1 : 0;
        else if (m_ph <= CH) nph = m_ph + 1;
        else                 nph = 0;
        if (m_ph >= 1 && m_ph <= CH && m_pend[m_ph-1]) begin
            m_ac[m_ph-1]   = m_sh[m_ph-1][SPLIT-1:0];
            m_pend[m_ph-1] = 1'b0;
        end
        if (ev) begin
            m_sh[addr]   = a_drv;
            m_pend[addr] = 1'b1;
        end
        m_ph = nph;
    endtask

    function automatic logic [WIDTH-1:0] exp_ch(input int c);
        if (mode[c]) return m_sh[c];
        return (m_sh[c] & TMASK) | WIDTH'(m_ac[c]);
    endfunction

    task automatic check_outputs();
        for (int c = 0; c < CH; c++)
            check_val($sformatf("obus_ch%0d", c), 64'(obus[c*WIDTH +: WIDTH]), 64'(exp_ch(c)));
        check_val("pend", 64'(pend), 64'(m_pend));
        check_val("busy", 64'(busy), 64'(m_ph != 0));
        check_val("ack",  64'(ack),  64'(m_ph == CH + 1));
        if (!ncs && dir)       check_val("abus_from_b", 64'(abus), 64'(b_drv));
        else if (!ncs && !dir) check_val("bbus_from_a", 64'(bbus), 64'(a_drv));
        else begin
            check_val("abus_idle", 64'(abus), 64'(a_drv));
            check_val("bbus_idle", 64'(bbus), 64'(b_drv));
        end
    endtask

    task automatic tick();
        apply_bus();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_write(input int c, input logic [WIDTH-1:0] d);
        addr = AW'(c); a_drv = d; wr = 1'b1;
        tick();
        wr = 1'b0;
        tick();
    endtask

    task automatic run_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        repeat (CH + 1) tick();
    endtask

    initial begin
        logic [CH-1:0]       pend_save;
        logic [CH*WIDTH-1:0] obus_save;

        rst = 1'b1; ncs = 1'b0; dir = 1'b0; wr = 1'b0; commit = 1'b0;
        addr = '0; mode = '0; a_drv = '0; b_drv = '0;
        apply_bus();
        model_reset();
        #2;
        check_outputs();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // Split field: only the transparent nibble shows before commit
        do_write(2, 16'hABCD);
        check_val("ch2_pre_commit", 64'(obus[47:32]), 64'h0000_0000_0000_A000);
        check_val("pend_ch2", 64'(pend), 64'b0100);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        repeat (3) tick();
        check_val("ch2_committed", 64'(obus[47:32]), 64'h0000_0000_0000_ABCD);
        tick();
        check_val("ack_pulse", 64'(ack), 64'd1);
        tick();
        check_val("ack_cleared", 64'(ack), 64'd0);
        check_val("pend_cleared", 64'(pend), 64'd0);

        // Whole-channel transparent mode
        mode = 4'b0010;
        addr = 3'd1; a_drv = 16'h1234; wr = 1'b1;
        tick();
        check_val("ch1_transparent", 64'(obus[31:16]), 64'h0000_0000_0000_1234);
        check_val("pend_ch1", 64'(pend[1]), 64'd1);
        wr = 1'b0;
        tick();
        run_commit();
        check_val("pend_ch1_clear", 64'(pend[1]), 64'd0);

        // Write colliding with the transfer of the same channel
        mode = 4'b0000;
        do_write(0, 16'h0FFF);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        addr = 3'd0; a_drv = 16'h0111; wr = 1'b1;
        tick();
        check_val("collide_active", 64'(obus[15:0]), 64'h0000_0000_0000_0FFF);
        check_val("collide_pend", 64'(pend[0]), 64'd1);
        wr = 1'b0;
        repeat (4) tick();
        check_val("collide_pend_hold", 64'(pend[0]), 64'd1);
        mode = 4'b0001;
        #1;
        check_val("collide_shadow", 64'(obus[15:0]), 64'h0000_0000_0000_0111);
        mode = 4'b0000;
        run_commit();
        check_val("collide_recommit", 64'(obus[15:0]), 64'h0000_0000_0000_0111);

        // Held strobe captures once; out-of-range address is ignored
        mode = 4'b1000;
        addr = 3'd3; wr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_drv = 16'h1111 * WIDTH'(i + 1);
            tick();
        end
        wr = 1'b0;
        tick();
        check_val("held_wr_once", 64'(obus[63:48]), 64'h0000_0000_0000_1111);
        pend_save = pend;
        obus_save = obus;
        do_write(5, 16'hDEAD);
        check_val("addr_oob_pend", 64'(pend), 64'(pend_save));
        check_val("addr_oob_obus", obus, obus_save);

        // Transceiver directions
        dir = 1'b1; b_drv = 16'h55AA; addr = 3'd1; wr = 1'b1;
        tick();
        check_val("b_to_a", 64'(abus), 64'h0000_0000_0000_55AA);
        check_val("b_to_a_nowrite", 64'(pend), 64'(pend_save));
        wr = 1'b0;
        tick();
        ncs = 1'b1; dir = 1'b0; a_drv = 16'h1357; b_drv = 16'h2468;
        tick();
        check_val("ncs_abus", 64'(abus), 64'h0000_0000_0000_1357);
        check_val("ncs_bbus", 64'(bbus), 64'h0000_0000_0000_2468);
        ncs = 1'b0;
        tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            wr     = 1'($urandom_range(0, 1));
            addr   = AW'($urandom_range(0, 7));
            a_drv  = WIDTH'($urandom);
            b_drv  = WIDTH'($urandom);
            ncs    = ($urandom_range(0, 7) == 0);
            dir    = ($urandom_range(0, 5) == 0);
            commit = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) mode = CH'($urandom);
            tick();
        end

        // Reset in the middle of a scan
        wr = 1'b0; ncs = 1'b0; dir = 1'b0; commit = 1'b0; mode = 4'b0000;
        repeat (CH + 2) tick();
        do_write(1, 16'hBEEF);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_obus", obus, 64'd0);
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nmk_latch_bank.md
# nmk_latch_bank

Parametrised successor to the NMK two-stage bus latch: a bidirectional A/B bus transceiver feeding a bank of CH write-addressed channel registers, each double-buffered. A single-clock commit engine transfers pending shadow values into the active registers on request, typically at vblank. It sits between the CPU data bus and the video scroll/tile-bank logic; OBUS drives the video side continuously.

## Interface
- WIDTH, 16, channel register width
- CH, 4, number of channels (≥2)
- SPLIT, 12, low bits [SPLIT-1:0] that are double-buffered; bits [WIDTH-1:SPLIT] are shadow-transparent (1 ≤ SPLIT ≤ WIDTH)
- AW, 2, channel address width, ≥ clog2(CH)
- CLK  in  1  system clock; all state changes on rising edge
- RST  in  1  reset, asynchronous, active-high
- nCS  in  1  chip select, active low
- DIR  in  1  transceiver direction: 1 = B→A, 0 = A→B
- WR  in  1  write strobe, active high, synchronous to CLK
- ADDR  in  AW  channel select for writes
- ABUS  inout  WIDTH  CPU-side bus
- BBUS  inout  WIDTH  peripheral-side bus
- COMMIT  in  1  commit request, level sampled
- MODE  in  CH  per channel: 1 = whole channel transparent (OBUS shows shadow), 0 = split double-buffered
- OBUS  out  CH*WIDTH  channel c at [c*WIDTH +: WIDTH]
- PEND  out  CH  channel c written since its last transfer
- BUSY  out  1  commit scan in progress
- ACK  out  1  one-cycle pulse, commit finished

## Operation
- Transceiver (combinational, unregistered): nCS=0,DIR=1 → ABUS=BBUS; nCS=0,DIR=0 → BBUS=ABUS; otherwise both Z. Never both driven.
- Write capture: wr_q = WR registered. Write event = WR & !wr_q & !nCS & !DIR. On event, shadow[ADDR] ← ABUS, PEND[ADDR] ← 1. Held WR gives one write only. ADDR ≥ CH: no write, no PEND change.
- OBUS channel c: MODE[c]=1 → shadow[c]; MODE[c]=0 → {shadow[c][WIDTH-1:SPLIT], active[c]}. SPLIT=WIDTH → no transparent field.
- Commit FSM states IDLE, SCAN, DONE:
  - IDLE: COMMIT=1 → SCAN, idx←0. Otherwise stay.
  - SCAN: if PEND[idx], active[idx] ← shadow[idx][SPLIT-1:0] and PEND[idx] cleared. idx==CH-1 → DONE, else idx+1.
  - DONE: ACK=1 for this cycle, → IDLE.
- BUSY=1 in SCAN and DONE. COMMIT ignored outside IDLE; COMMIT held high re-triggers from IDLE the cycle after DONE.
- Channels transfer regardless of MODE (active kept current for later MODE=0).

## Timing
- Reset (async assert, takes effect immediately): shadow, active, PEND, wr_q, idx = 0; state IDLE; BUSY=0, ACK=0; OBUS=0. Reset mid-SCAN aborts, no partial ACK.
- Write: shadow/PEND visible on OBUS/PEND the cycle after the capturing edge.
- Commit latency: COMMIT sampled at edge n → SCAN n+1..n+CH → ACK high in cycle n+CH+1 → IDLE n+CH+2. Channel c's active updates at edge n+1+c.
- Write and transfer same edge, same channel: shadow takes new data, active takes old shadow, PEND stays 1 (set wins).
- Write during SCAN to channel already scanned: PEND set, waits for next commit. To channel not yet scanned: transferred in this scan.
- Transparent bits and MODE=1 channels change with no commit.

## Test plan
- Reset: RST pulse mid-SCAN → OBUS all 0, PEND=0, BUSY=0, no ACK; after release, IDLE.
- Write ch2 0xABCD (WIDTH16,SPLIT12,MODE=0) → OBUS ch2 = 0xA000, PEND=0b0100; COMMIT → ch2 = 0xABCD at edge n+3, ACK in cycle n+5, PEND=0.
- MODE[1]=1, write ch1 0x1234 → OBUS ch1 = 0x1234 next cycle without commit; PEND[1]=1 until committed.
- Collision: write ch0 0x0111 at commit edge n+1 after shadow 0x0FFF → active ch0 = 0xFFF, shadow 0x0111, PEND[0] stays 1.
- WR held 5 cycles with changing ABUS → single capture of first value; ADDR=5 with CH=4 → no change.
- Transceiver: nCS=0 DIR=1 BBUS=0x55AA → ABUS=0x55AA, no write event; nCS=1 → both buses Z.
